spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Single-channel SPI master (SPI mode 0, MSB first, one slave select).
//  Sits between a local command interface and an external SPI slave.
//  Shifts out up to SPI_MAXLEN bits of tx_data on MOSI and captures the same
//  number of bits from MISO into rx_miso. SCLK is derived from clk by an
//  integer divider.
// PARAMETERS
//  CLK_DIVIDE  4   clk cycles per SCLK period; even, >=2; half period H=CLK_DIVIDE/2
//  SPI_MAXLEN  32  maximum bits per transfer; width of tx_data/rx_miso
// PORTS
//  clk          in   1                    system clock, all logic on rising edge
//  sresetn      in   1                    reset, asynchronous, active-low
//  start_cmd    in   1                    transfer request, level-sampled while idle
//  spi_drv_rdy  out  1                    1 = idle/accepting, 0 = transfer in progress
//  n_clks       in   $clog2(SPI_MAXLEN)+1 bit count N for the transfer (1..SPI_MAXLEN)
//  tx_data      in   SPI_MAXLEN           data to send, right-justified: bits [N-1:0]
//  rx_miso      out  SPI_MAXLEN           received data, right-justified, upper bits 0
//  SCLK         out  1                    SPI clock, idle low
//  MOSI         out  1                    master out, idle 0
//  MISO         in   1                    master in
//  SS_N         out  1                    slave select, active low, idle high
// BEHAVIOUR
//  Reset (sresetn=0, async): SCLK=0, MOSI=0, SS_N=1, spi_drv_rdy=1, rx_miso=0.
//   Reset also aborts a transfer in progress immediately. No partial rx_miso update.
//  FSM: IDLE -> LEAD -> SCLK_HI -> SCLK_LO -> (SCLK_HI | TRAIL) -> IDLE.
//  IDLE: rdy=1. On a clk edge with start_cmd=1 and 1<=n_clks: latch tx_data and
//   N = min(n_clks, SPI_MAXLEN). Next cycle: rdy=0, SS_N=0, MOSI=tx[N-1] -> LEAD.
//   n_clks=0: request ignored, stays IDLE.
//  LEAD: hold H clks, then SCLK rises -> SCLK_HI.
//  SCLK_HI: hold H clks, then SCLK falls. On the same edge:
//   - sample MISO into rx shift register (shift left, LSB in);
//   - if bits remain, drive the next tx bit on MOSI -> SCLK_LO;
//   - else -> TRAIL.
//  SCLK_LO: hold H clks, then SCLK rises -> SCLK_HI.
//  MISO is sampled on the falling edge, one half period after the slave's rising
//   edge. A slave that registers MOSI onto MISO at posedge SCLK therefore loops
//   back tx bits exactly.
//  TRAIL: hold H clks, then in one cycle: SS_N=1, MOSI=0, rx_miso <= rx shift
//   register (bits [N-1:0], upper bits 0), rdy=1 -> IDLE.
//  Counts: exactly N SCLK rising edges per transfer.
//   SS_N low for (2N+1)*H clks. N=16, CLK_DIVIDE=4: 66 clks.
//  tx_data and n_clks changes after acceptance are ignored.
//   rx_miso only changes at transfer completion or reset.
//  start_cmd held high: a new transfer is accepted on the first IDLE cycle
//   (back-to-back, at least 1 idle cycle with rdy=1 between transfers).
//  Counters: bit counter $clog2(SPI_MAXLEN)+1 bits; divider counter
//   $clog2(CLK_DIVIDE) bits. No wrap within a legal transfer.
// TESTING (CLK_DIVIDE=4, SPI_MAXLEN=16, MISO <= MOSI on posedge SCLK while SS_N=0)
//  1. Reset, n_clks=16, tx_data=16'hA5A5, start_cmd=1
//     -> rdy low, 16 SCLK pulses, SS_N low 66 clks, then rdy=1, rx_miso=16'hA5A5.
//  2. Reset, tx_data=16'h3B46, n_clks=16 -> rx_miso=16'h3B46; MOSI stream MSB first 0011...
//  3. n_clks=8, tx_data=16'h00C3 -> 8 SCLK rising edges, SS_N low 34 clks, rx_miso=16'h00C3.
//  4. MISO tied 1, n_clks=16 -> rx_miso=16'hFFFF; MISO tied 0 -> rx_miso=16'h0000.
//  5. Assert sresetn=0 mid-transfer (after 5 SCLK edges) -> same-cycle SS_N=1, SCLK=0,
//     rdy=1, rx_miso=0; next start completes normally.
//  6. Change tx_data/n_clks mid-transfer; also n_clks=0 with start_cmd=1
//     -> original transfer result unaffected; n_clks=0 leaves rdy=1, SS_N=1.

Source files
------------

// File: rtl/spi_master.sv
// SPI master, mode 0 (SCLK idle low, data launched on the falling edge, sampled
// on the rising edge by the slave), MSB first, single slave select.
// SCLK, MOSI and SS_N are all registered, so they have no combinational glitches.
module spi_master #(
  parameter int CLK_DIVIDE = 4,
  parameter int SPI_MAXLEN = 32
) (
  input  logic                        clk,
  input  logic                        sresetn,
  input  logic                        start_cmd,
  output logic                        spi_drv_rdy,
  input  logic [$clog2(SPI_MAXLEN):0] n_clks,
  input  logic [SPI_MAXLEN-1:0]       tx_data,
  output logic [SPI_MAXLEN-1:0]       rx_miso,
  output logic                        SCLK,
  output logic                        MOSI,
  input  logic                        MISO,
  output logic                        SS_N
);

  localparam int NW = $clog2(SPI_MAXLEN) + 1;
  localparam int DW = $clog2(CLK_DIVIDE);
  localparam int H  = CLK_DIVIDE / 2;
  localparam logic [DW-1:0] HALF_LAST = DW'(H - 1);
  localparam logic [NW-1:0] MAXLEN_N  = NW'(SPI_MAXLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SCLK_HI,
    S_SCLK_LO,
    S_TRAIL
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DW-1:0]         r_div, w_div_nxt;
  logic [NW-1:0]         r_cnt, w_cnt_nxt;
  logic [SPI_MAXLEN-1:0] r_tx, w_tx_nxt;
  logic [SPI_MAXLEN-1:0] r_rx, w_rx_nxt;
  logic [SPI_MAXLEN-1:0] r_rx_out, w_rx_out_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_mosi, w_mosi_nxt;
  logic                  r_ssn, w_ssn_nxt;
  logic                  r_rdy, w_rdy_nxt;

  logic                  w_half_done;
  logic [NW-1:0]         w_len;
  logic [SPI_MAXLEN-1:0] w_tx_load;

  // Oversized requests are clamped to the shift register width; the transmit
  // word is left-aligned so the current bit is always the register MSB.
  assign w_half_done = (r_div == HALF_LAST);
  assign w_len       = (n_clks > MAXLEN_N) ? MAXLEN_N : n_clks;
  assign w_tx_load   = tx_data << (MAXLEN_N - w_len);

  assign SCLK        = r_sclk;
  assign MOSI        = r_mosi;
  assign SS_N        = r_ssn;
  assign spi_drv_rdy = r_rdy;
  assign rx_miso     = r_rx_out;

  // State and datapath registers; reset aborts any transfer immediately
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rx_out <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_ssn    <= 1'b1;
      r_rdy    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tx     <= w_tx_nxt;
      r_rx     <= w_rx_nxt;
      r_rx_out <= w_rx_out_nxt;
      r_sclk   <= w_sclk_nxt;
      r_mosi   <= w_mosi_nxt;
      r_ssn    <= w_ssn_nxt;
      r_rdy    <= w_rdy_nxt;
    end
  end

  // Next-state and next-output logic; every non-idle state lasts H clocks
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_cnt_nxt    = r_cnt;
    w_tx_nxt     = r_tx;
    w_rx_nxt     = r_rx;
    w_rx_out_nxt = r_rx_out;
    w_sclk_nxt   = r_sclk;
    w_mosi_nxt   = r_mosi;
    w_ssn_nxt    = r_ssn;
    w_rdy_nxt    = r_rdy;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_half_done ? '0 : r_div + DW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start_cmd && (n_clks != '0)) begin
          w_tx_nxt    = w_tx_load;
          w_cnt_nxt   = w_len;
          w_rx_nxt    = '0;
          w_div_nxt   = '0;
          w_ssn_nxt   = 1'b0;
          w_rdy_nxt   = 1'b0;
          w_mosi_nxt  = w_tx_load[SPI_MAXLEN-1];
          w_state_nxt = S_LEAD;
        end
      end
      S_LEAD: begin
        if (w_half_done) begin
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_SCLK_HI;
        end
      end
      S_SCLK_HI: begin
        if (w_half_done) begin
          w_sclk_nxt = 1'b0;
          w_rx_nxt   = {r_rx[SPI_MAXLEN-2:0], MISO};
          w_cnt_nxt  = r_cnt - NW'(1);
          if (r_cnt > NW'(1)) begin
            w_tx_nxt    = {r_tx[SPI_MAXLEN-2:0], 1'b0};
            w_mosi_nxt  = r_tx[SPI_MAXLEN-2];
            w_state_nxt = S_SCLK_LO;
          end else begin
            w_state_nxt = S_TRAIL;
          end
        end
      end
      S_SCLK_LO: begin
        if (w_half_done) begin
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_SCLK_HI;
        end
      end
      S_TRAIL: begin
        if (w_half_done) begin
          w_ssn_nxt    = 1'b1;
          w_mosi_nxt   = 1'b0;
          w_rx_out_nxt = r_rx;
          w_rdy_nxt    = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (CLK_DIVIDE=4, SPI_MAXLEN=16) with a loopback
// slave that registers MOSI onto MISO at posedge SCLK while selected.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic        start_cmd = 1'b0;
  logic        spi_drv_rdy;
  logic [4:0]  n_clks = '0;
  logic [15:0] tx_data = '0;
  logic [15:0] rx_miso;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        SS_N;

  logic        r_lb = 1'b0;
  int          miso_mode = 0;   // 0 loopback, 1 tied high, 2 tied low
  int          sclk_edges = 0;
  int          ss_low_clks = 0;
  logic [15:0] mosi_cap = '0;
  int          total = 0;
  int          bad = 0;

  spi_master #(.CLK_DIVIDE(4), .SPI_MAXLEN(16)) u_dut (
    .clk         (clk),
    .sresetn     (sresetn),
    .start_cmd   (start_cmd),
    .spi_drv_rdy (spi_drv_rdy),
    .n_clks      (n_clks),
    .tx_data     (tx_data),
    .rx_miso     (rx_miso),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .SS_N        (SS_N)
  );

  always #5 clk = ~clk;

  assign MISO = (miso_mode == 0) ? r_lb : (miso_mode == 1);

  // Loopback slave and MOSI stream capture
  always @(posedge SCLK) begin
    if (!SS_N) r_lb <= MOSI;
    sclk_edges = sclk_edges + 1;
    mosi_cap   = {mosi_cap[14:0], MOSI};
  end

  // Clocks with SS_N low (value seen just before each edge)
  always @(posedge clk) begin
    if (!SS_N) ss_low_clks = ss_low_clks + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 2000 && !spi_drv_rdy; i++) @(negedge clk);
    check_eq("rdy_timeout", {31'd0, spi_drv_rdy}, 32'd1);
  endtask

  task automatic launch(input logic [4:0] n, input logic [15:0] d);
    wait_rdy();
    sclk_edges  = 0;
    ss_low_clks = 0;
    mosi_cap    = '0;
    n_clks      = n;
    tx_data     = d;
    start_cmd   = 1'b1;
    @(posedge clk);
    #1;
    start_cmd = 1'b0;
    check_eq("busy_rdy", {31'd0, spi_drv_rdy}, 32'd0);
    check_eq("busy_ssn", {31'd0, SS_N}, 32'd0);
  endtask

  task automatic xfer(input string tag, input logic [4:0] n, input logic [15:0] d,
                      input logic [15:0] exp_rx, input int exp_edges,
                      input int exp_ss, input logic [15:0] exp_mosi);
    launch(n, d);
    wait_rdy();
    @(negedge clk);
    check_eq({tag, "_rx"}, {16'd0, rx_miso}, {16'd0, exp_rx});
    check_eq({tag, "_edges"}, sclk_edges, exp_edges);
    check_eq({tag, "_sslow"}, ss_low_clks, exp_ss);
    check_eq({tag, "_mosi"}, {16'd0, mosi_cap}, {16'd0, exp_mosi});
    check_eq({tag, "_ssn_idle"}, {31'd0, SS_N}, 32'd1);
    check_eq({tag, "_sclk_idle"}, {31'd0, SCLK}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", {31'd0, spi_drv_rdy}, 32'd1);
    check_eq("rst_ssn", {31'd0, SS_N}, 32'd1);
    check_eq("rst_sclk", {31'd0, SCLK}, 32'd0);
    check_eq("rst_mosi", {31'd0, MOSI}, 32'd0);
    check_eq("rst_rx", {16'd0, rx_miso}, 32'd0);
    sresetn = 1'b1;
    @(negedge clk);

    // Full-width loopback transfers; MOSI capture holds the stream MSB first
    xfer("t1", 5'd16, 16'hA5A5, 16'hA5A5, 16, 66, 16'hA5A5);
    xfer("t2", 5'd16, 16'h3B46, 16'h3B46, 16, 66, 16'h3B46);
    // Short, single-bit and clamped lengths
    xfer("t3", 5'd8,  16'h00C3, 16'h00C3, 8, 34, 16'h00C3);
    xfer("t1b", 5'd1, 16'hFFFF, 16'h0001, 1, 6, 16'h0001);
    xfer("tclmp", 5'd20, 16'h1234, 16'h1234, 16, 66, 16'h1234);

    // MISO tied high / low
    miso_mode = 1;
    xfer("t4hi", 5'd16, 16'h0000, 16'hFFFF, 16, 66, 16'h0000);
    xfer("t4hi8", 5'd8, 16'h0000, 16'h00FF, 8, 34, 16'h0000);
    miso_mode = 2;
    xfer("t4lo", 5'd16, 16'hFFFF, 16'h0000, 16, 66, 16'hFFFF);
    miso_mode = 0;
    xfer("t4re", 5'd16, 16'hBEEF, 16'hBEEF, 16, 66, 16'hBEEF);

    // Asynchronous reset after 5 SCLK rising edges
    launch(5'd16, 16'h5A5A);
    for (int i = 0; i < 500 && sclk_edges < 5; i++) @(posedge clk);
    check_eq("t5_reach5", {31'd0, sclk_edges >= 5}, 32'd1);
    #2;
    sresetn = 1'b0;
    #1;
    check_eq("t5_ssn", {31'd0, SS_N}, 32'd1);
    check_eq("t5_sclk", {31'd0, SCLK}, 32'd0);
    check_eq("t5_rdy", {31'd0, spi_drv_rdy}, 32'd1);
    check_eq("t5_rx", {16'd0, rx_miso}, 32'd0);
    @(negedge clk);
    sresetn = 1'b1;
    @(negedge clk);
    xfer("t5post", 5'd16, 16'hC0DE, 16'hC0DE, 16, 66, 16'hC0DE);

    // Inputs changed after acceptance must not affect the transfer
    launch(5'd16, 16'h3C5A);
    tx_data = 16'hFFFF;
    n_clks  = 5'd4;
    wait_rdy();
    @(negedge clk);
    check_eq("t6_rx", {16'd0, rx_miso}, 32'h3C5A);
    check_eq("t6_edges", sclk_edges, 16);
    check_eq("t6_sslow", ss_low_clks, 66);

    // Zero-length request is ignored
    n_clks    = 5'd0;
    start_cmd = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t6_n0_rdy", {31'd0, spi_drv_rdy}, 32'd1);
    check_eq("t6_n0_ssn", {31'd0, SS_N}, 32'd1);
    check_eq("t6_n0_rx", {16'd0, rx_miso}, 32'h3C5A);

    // start_cmd held high: one idle cycle with rdy=1, then the next transfer
    n_clks  = 5'd4;
    tx_data = 16'h000A;
    @(negedge clk);
    check_eq("b2b_busy1", {31'd0, spi_drv_rdy}, 32'd0);
    wait_rdy();
    check_eq("b2b_rx1", {16'd0, rx_miso}, 32'h000A);
    tx_data = 16'h0005;
    @(negedge clk);
    check_eq("b2b_busy2", {31'd0, spi_drv_rdy}, 32'd0);
    check_eq("b2b_ssn2", {31'd0, SS_N}, 32'd0);
    start_cmd = 1'b0;
    wait_rdy();
    @(negedge clk);
    check_eq("b2b_rx2", {16'd0, rx_miso}, 32'h0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
